// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller and its datapath:
// FSM states, opcodes, and the mux/ALU select codes both sides must agree on.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MDR       = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_AREG  = 2'b10;

  localparam logic [1:0] SRCB_BREG = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  function automatic logic [2:0] imm_for_opcode(input logic [6:0] op);
    case (op)
      OP_IALU, OP_LW, OP_JALR: imm_for_opcode = IMM_I;
      OP_SW:                   imm_for_opcode = IMM_S;
      OP_BR:                   imm_for_opcode = IMM_B;
      OP_JAL:                  imm_for_opcode = IMM_J;
      OP_LUI:                  imm_for_opcode = IMM_U;
      default:                 imm_for_opcode = IMM_I;
    endcase
  endfunction

  // beq/bne test the subtract result for zero; blt/bge use its sign bit.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic sign);
    case (f3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = sign;
      3'b101:  branch_taken = ~sign;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decoder: fixed add/sub requests pass through, otherwise the
// operation comes from func3 (with func7[5] selecting sub only for R-type).
module alu_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       is_rtype,
  output logic [2:0] ALUControl
);

  // Decode ALU operation from ALUOp and the instruction function fields.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNC: begin
        case (func3)
          3'b000: begin
            if (is_rtype && func7_5) begin
              ALUControl = ALU_SUB;
            end else begin
              ALUControl = ALU_ADD;
            end
          end
          3'b111:  ALUControl = ALU_AND;
          3'b110:  ALUControl = ALU_OR;
          3'b100:  ALUControl = ALU_XOR;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V controller: one FSM state register, Moore-style outputs
// decoded from state (plus instruction fields/flags), enables gated by reset.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_is_rtype;
  logic [1:0] w_alu_op;
  logic       w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_is_rtype = 1'b0;
    w_alu_op   = ALUOP_ADD;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_BREG;
    ImmSrc     = imm_for_opcode(opcode);
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + B-imm precomputes the branch target while decoding.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_IALU:      w_next = S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR1;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_AREG;
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_SW) begin
          ImmSrc = IMM_S;
          w_next = S_MEMWRITE;
        end else begin
          ImmSrc = IMM_I;
          w_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_MDR;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_AREG;
        w_alu_op   = ALUOP_FUNC;
        w_is_rtype = 1'b1;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_AREG;
        ALUSrcB  = SRCB_IMM;
        ImmSrc   = IMM_I;
        w_alu_op = ALUOP_FUNC;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_AREG;
        w_alu_op  = ALUOP_SUB;
        ImmSrc    = IMM_B;
        w_pcwrite = branch_taken(func3, zero, sign);
        w_next    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ImmSrc    = IMM_J;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = SRCA_AREG;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        w_next  = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_LUI: begin
        ImmSrc     = IMM_U;
        ResultSrc  = RES_IMMEXT;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (w_alu_op),
    .func3      (func3),
    .func7_5    (func7[5]),
    .is_rtype   (w_is_rtype),
    .ALUControl (ALUControl)
  );

  // State is already FETCH during reset, so only the write enables need masking.
  assign PCWrite  = w_pcwrite  & ~rst;
  assign MemWrite = w_memwrite & ~rst;
  assign IRWrite  = w_irwrite  & ~rst;
  assign RegWrite = w_regwrite & ~rst;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// vectors; every cycle one vector is popped and compared against the outputs.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] func3 = 3'b000;
  logic [6:0] func7 = 7'b0000000;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int n_pass = 0;
  int n_total = 0;
  logic [16:0] exp_q[$];

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .sign(sign), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%b exp=%b (pcw,adr,mw,irw,rw,rs,sa,sb,alu,imm)", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] v(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, sa, sb,
                                    input logic [2:0] alu, imm);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm};
  endfunction

  function automatic logic [16:0] observed();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ALUControl, ImmSrc};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      3'b011:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_seq(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input logic s);
    logic [2:0]  im;
    logic [16:0] wb;
    im = imm_of(op);
    wb = v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, im);
    exp_q.push_back(v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, im));
    exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010));
    case (op)
      7'b0000011: begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
        exp_q.push_back(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im));
        exp_q.push_back(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, im));
      end
      7'b0100011: begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001));
        exp_q.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im));
      end
      7'b0110011: begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7[5]), im));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(f3, 1'b0), 3'b000));
        exp_q.push_back(wb);
      end
      7'b1100011: begin
        exp_q.push_back(v(taken_of(f3, z, s), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010));
      end
      7'b1101111: begin
        exp_q.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011));
        exp_q.push_back(wb);
      end
      7'b1100111: begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
        exp_q.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, im));
        exp_q.push_back(wb);
      end
      7'b0110111: begin
        exp_q.push_back(v(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100));
      end
      default: ;
    endcase
  endtask

  // Called in the clock-low phase; checks one vector per cycle until the
  // scoreboard is drained, leaving the DUT back in FETCH.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic s);
    int cyc;
    opcode = op; func3 = f3; func7 = f7; zero = z; sign = s;
    push_seq(op, f3, f7, z, s);
    cyc = 0;
    while (exp_q.size() > 0) begin
      #1;
      check_val($sformatf("%s c%0d", name, cyc), observed(), exp_q.pop_front());
      cyc++;
      @(negedge clk);
    end
  endtask

  logic [16:0] rst_vec;

  initial begin
    rst_vec = v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(7'b0110011));
    @(negedge clk);
    #1 check_val("reset", observed(), rst_vec);
    @(negedge clk);
    #1 check_val("reset_hold", observed(), rst_vec);
    rst = 1'b0;

    run_instr("r_sub",   7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr("r_add",   7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("r_and",   7'b0110011, 3'b111, 7'b0000000, 1'b0, 1'b0);
    run_instr("r_slt",   7'b0110011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    run_instr("i_add7",  7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr("i_xor",   7'b0010011, 3'b100, 7'b0000000, 1'b0, 1'b0);
    run_instr("i_sltu",  7'b0010011, 3'b011, 7'b0000000, 1'b0, 1'b0);
    run_instr("i_or",    7'b0010011, 3'b110, 7'b0000000, 1'b0, 1'b0);
    run_instr("i_f001",  7'b0010011, 3'b001, 7'b0000000, 1'b0, 1'b0);
    run_instr("lw",      7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    run_instr("sw",      7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    run_instr("bne_z1",  7'b1100011, 3'b001, 7'b0000000, 1'b1, 1'b0);
    run_instr("bne_z0",  7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0);
    run_instr("beq_z1",  7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0);
    run_instr("beq_z0",  7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b1);
    run_instr("blt_s1",  7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1);
    run_instr("bge_s1",  7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1);
    run_instr("bge_s0",  7'b1100011, 3'b101, 7'b0000000, 1'b1, 1'b0);
    run_instr("b_f010",  7'b1100011, 3'b010, 7'b0000000, 1'b1, 1'b1);
    run_instr("jal",     7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("jalr",    7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("lui",     7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("bad_op",  7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0);

    // Reset asserted between clock edges while the LW sits in MEMREAD.
    opcode = 7'b0000011; func3 = 3'b010; func7 = 7'b0000000;
    push_seq(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1 check_val($sformatf("lw_pre c%0d", c), observed(), exp_q.pop_front());
      if (c < 3) @(negedge clk);
    end
    exp_q.delete();
    rst_vec = v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(7'b0000011));
    #1 rst = 1'b1;
    #1 check_val("rst_mid_lw", observed(), rst_vec);
    @(negedge clk);
    #1 check_val("rst_mid_hold", observed(), rst_vec);
    rst = 1'b0;

    run_instr("lw_after", 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    run_instr("r_final",  7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7  Instr[6:0] from datapath.
REQ-005 func3  in  3  Instr[14:12].
REQ-006 func7  in  7  Instr[31:25].
REQ-007 zero, sign  in  1 each  ALU flags (result==0, result[31]).
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-009 ResultSrc  out  2  00 ALUOut, 01 MDR, 10 ALUResult, 11 ImmExt.
REQ-010 ALUSrcA  out  2  00 PC, 01 OldPC, 10 A-reg.
REQ-011 ALUSrcB  out  2  00 B-reg, 01 ImmExt, 10 constant 4.
REQ-012 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
REQ-013 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.

Function
REQ-014 Opcodes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
REQ-015 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI.
REQ-016 Outputs SHALL be combinational from state (plus opcode/func3/func7/zero/sign where stated); unlisted outputs in any state are 0 / 00 / add / ImmSrc per opcode.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1; next DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add; next by opcode: LW/SW->MEMADR, R->EXECR, I-ALU->EXECI, BR->BRANCH, JAL->JAL, JALR->JALR1, LUI->LUI, any other->FETCH (no writes).
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc I (LW) or S (SW); next MEMREAD (LW) or MEMWRITE (SW).
REQ-020 MEMREAD: AdrSrc=1, ResultSrc=00; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-021 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; next FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from func3/func7; EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc I, ALUControl from func3; both next ALUWB.
REQ-023 ALU decode: func3 000 add (sub only in EXECR with func7[5]=1), 111 and, 110 or, 100 xor, 010 slt, 011 sltu; other func3 -> add.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, ImmSrc B; PCWrite=1 iff func3 000&zero, 001&!zero, 100&sign, 101&!sign; other func3 never taken; next FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, ImmSrc J; next ALUWB.
REQ-027 JALR1: ALUSrcA=10, ALUSrcB=01, add, ImmSrc I; next JALR2. JALR2: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-028 LUI: ImmSrc U, ResultSrc=11, RegWrite=1; next FETCH.
REQ-029 Latencies (cycles incl. FETCH): R/I/SW/JAL 4, LW/JALR 5, BR/LUI 3, unknown opcode 2.
REQ-030 At most one of MemWrite, RegWrite SHALL be 1 in any cycle; IRWrite=1 only in FETCH.

Reset
REQ-031 rst=1 SHALL force state to FETCH immediately, independent of clk, including mid-instruction.
REQ-032 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite SHALL be 0; selects take FETCH values.
REQ-033 First rising edge after rst falls SHALL execute FETCH with full FETCH outputs.

Structure
REQ-034 State encoding, opcode constants, ALUControl, ImmSrc, ResultSrc and ALUSrcA/B codes SHALL live in a shared package used by controller and datapath.
REQ-035 ALU-control decoding SHALL be a sub-module alu_decoder (inputs ALUOp[2], func3, func7[5], is_rtype; output ALUControl).

Verification
REQ-036 Reset mid-LW (assert rst in MEMREAD) -> state FETCH same cycle, all enables 0 until release.
REQ-037 opcode 0110011, func3 000, func7 0100000 -> FETCH,DECODE,EXECR(ALUControl 001),ALUWB(RegWrite 1), back to FETCH.
REQ-038 BR func3 001 with zero=1 -> PCWrite 0 in BRANCH; zero=0 -> PCWrite 1.
REQ-039 LW -> exactly 5 cycles, MemWrite never 1, AdrSrc 1 in MEMREAD, ResultSrc 01 with RegWrite 1 in MEMWB.
REQ-040 JALR -> PCWrite 1 only in FETCH and JALR2, RegWrite 1 only in ALUWB.
REQ-041 opcode 1111111 -> DECODE then FETCH, no RegWrite/MemWrite asserted.
